// File: rtl/decoder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : decoder_pipe_pkg
// Brief    : Shared mode encoding and width helper for the pipelined decoder.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'b00,
        MODE_SET     = 2'b01,
        MODE_CLR     = 2'b10,
        MODE_CLR_ALL = 2'b11
    } mode_t;

    // Population count of an OUT_N-bit vector needs to reach OUT_N itself.
    function automatic int cnt_width(input int out_n);
        return $clog2(out_n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_predec.sv
`default_nettype none
// ============================================================================
// Module   : decoder_predec
// Brief    : Stage-1 register of the decoder pipe: hi/lo one-hot predecode,
//            out-of-range flag and mode, with its own valid/advance logic.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_predec
    import decoder_pipe_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_N = 1024,
    parameter int SPLIT = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [IN_W-1:0]             in_sel,
    input  logic [1:0]                  in_mode,
    input  logic                        s2_adv,
    output logic                        s1_adv,
    output logic                        s1_valid,
    output logic [2**(IN_W-SPLIT)-1:0]  hi_oh,
    output logic [2**SPLIT-1:0]         lo_oh,
    output logic                        err,
    output mode_t                       mode
);

    localparam int            c_hi_n  = 2**(IN_W-SPLIT);
    localparam int            c_lo_n  = 2**SPLIT;
    // One extra bit so OUT_N == 2**IN_W is representable and never trips err.
    localparam logic [IN_W:0] c_out_n = (IN_W+1)'(OUT_N);

    logic              r_valid;
    logic [c_hi_n-1:0] r_hi_oh;
    logic [c_lo_n-1:0] r_lo_oh;
    logic              r_err;
    mode_t             r_mode;

    logic [c_hi_n-1:0] w_hi_oh;
    logic [c_lo_n-1:0] w_lo_oh;
    logic              w_err;
    logic              w_s1_adv;
    mode_t             w_mode;

    assign w_mode   = mode_t'(in_mode);
    assign w_s1_adv = !r_valid || s2_adv;
    assign w_err    = ({1'b0, in_sel} >= c_out_n) && (w_mode != MODE_CLR_ALL);

    always_comb begin
        w_hi_oh = '0;
        w_lo_oh = '0;
        w_hi_oh[in_sel[IN_W-1:SPLIT]] = 1'b1;
        w_lo_oh[in_sel[SPLIT-1:0]]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_hi_oh <= '0;
            r_lo_oh <= '0;
            r_err   <= 1'b0;
            r_mode  <= MODE_ONEHOT;
        end else if (w_s1_adv) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_hi_oh <= w_hi_oh;
                r_lo_oh <= w_lo_oh;
                r_err   <= w_err;
                r_mode  <= w_mode;
            end
        end
    end

    assign s1_adv   = w_s1_adv;
    assign s1_valid = r_valid;
    assign hi_oh    = r_hi_oh;
    assign lo_oh    = r_lo_oh;
    assign err      = r_err;
    assign mode     = r_mode;

endmodule
`default_nettype wire

// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pipe
// Brief    : Two-stage valid/ready binary-to-vector decoder with stateful
//            ONEHOT/SET/CLR/CLR_ALL output and out-of-range flagging.
//            Define DECODER_PIPE_COUNT_EN to add the out_cnt popcount port.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_N = 1024,
    parameter int SPLIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_sel,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_N-1:0]  out_vec,
    output logic              out_err
`ifdef DECODER_PIPE_COUNT_EN
    ,
    output logic [cnt_width(OUT_N)-1:0] out_cnt
`endif
);

    localparam int c_hi_n  = 2**(IN_W-SPLIT);
    localparam int c_lo_n  = 2**SPLIT;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_s1_valid;
    logic [c_hi_n-1:0] w_hi_oh;
    logic [c_lo_n-1:0] w_lo_oh;
    logic              w_err;
    mode_t             w_mode;
    logic [OUT_N-1:0]  w_oh_raw;
    logic [OUT_N-1:0]  w_oh;
    logic [OUT_N-1:0]  w_vec_nxt;

    logic              r_out_valid;
    logic [OUT_N-1:0]  r_vec;
    logic              r_err;

    decoder_predec #(
        .IN_W  (IN_W),
        .OUT_N (OUT_N),
        .SPLIT (SPLIT)
    ) u_predec (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_mode  (in_mode),
        .s2_adv   (w_s2_adv),
        .s1_adv   (w_s1_adv),
        .s1_valid (w_s1_valid),
        .hi_oh    (w_hi_oh),
        .lo_oh    (w_lo_oh),
        .err      (w_err),
        .mode     (w_mode)
    );

    assign w_s2_adv = !r_out_valid || out_ready;

    for (genvar i = 0; i < OUT_N; i++) begin : g_oh
        assign w_oh_raw[i] = w_hi_oh[i >> SPLIT] & w_lo_oh[i % c_lo_n];
    end

    // An out-of-range select must not touch any bit.
    assign w_oh = w_err ? '0 : w_oh_raw;

    always_comb begin
        w_vec_nxt = r_vec;
        case (w_mode)
            MODE_ONEHOT:  w_vec_nxt = w_oh;
            MODE_SET:     w_vec_nxt = r_vec | w_oh;
            MODE_CLR:     w_vec_nxt = r_vec & ~w_oh;
            MODE_CLR_ALL: w_vec_nxt = '0;
            default:      w_vec_nxt = r_vec;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_vec       <= '0;
            r_err       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= w_s1_valid;
            if (w_s1_valid) begin
                r_vec <= w_vec_nxt;
                r_err <= w_err;
            end
        end
    end

`ifdef DECODER_PIPE_COUNT_EN
    localparam int c_cnt_w = cnt_width(OUT_N);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_hit;

    // Target bit already set in the current vector (zero when err masks oh).
    assign w_hit = |(r_vec & w_oh);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case (w_mode)
            MODE_ONEHOT:  w_cnt_nxt = w_err ? '0 : c_cnt_w'(1);
            MODE_SET:     w_cnt_nxt = (!w_err && !w_hit) ? r_cnt + c_cnt_w'(1) : r_cnt;
            MODE_CLR:     w_cnt_nxt = w_hit ? r_cnt - c_cnt_w'(1) : r_cnt;
            MODE_CLR_ALL: w_cnt_nxt = '0;
            default:      w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_s2_adv && w_s1_valid) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign out_cnt = r_cnt;
`endif

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign out_vec   = r_vec;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_pipe
// Brief    : Self-checking bench for decoder_pipe: directed vector table,
//            multi-cycle corner sequences and randomized scoreboard traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_pipe;
    import decoder_pipe_pkg::*;

    localparam int IN_W  = 10;
    localparam int OUT_N = 1000;
    localparam int SPLIT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, out_err;
    logic [IN_W-1:0]  in_sel;
    logic [1:0]       in_mode;
    logic [OUT_N-1:0] out_vec;
`ifdef DECODER_PIPE_COUNT_EN
    logic [$clog2(OUT_N+1)-1:0] out_cnt;
`endif

    // Full-range instance: OUT_N == 2**IN_W, so err can never be raised.
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_err;
    logic [3:0]  b_in_sel;
    logic [1:0]  b_in_mode;
    logic [15:0] b_out_vec;
`ifdef DECODER_PIPE_COUNT_EN
    logic [4:0]  b_out_cnt;
`endif

    decoder_pipe #(.IN_W(IN_W), .OUT_N(OUT_N), .SPLIT(SPLIT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_err(out_err)
`ifdef DECODER_PIPE_COUNT_EN
        , .out_cnt(out_cnt)
`endif
    );

    decoder_pipe #(.IN_W(4), .OUT_N(16), .SPLIT(2)) dut_full (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_vec(b_out_vec), .out_err(b_out_err)
`ifdef DECODER_PIPE_COUNT_EN
        , .out_cnt(b_out_cnt)
`endif
    );

    typedef struct {
        logic [OUT_N-1:0] vec;
        logic             err;
        int               cnt;
        int               cyc;
    } res_t;

    typedef struct {
        logic [1:0]       mode;
        int               sel;
        logic [OUT_N-1:0] vec;
        logic             err;
        int               cnt;
    } vec_t;

    int               nvec = 0;
    int               nerr = 0;
    int               nacc = 0;
    int               cyc  = 0;
    logic [OUT_N-1:0] mvec;
    logic [OUT_N-1:0] mlast;
    res_t             q[$];
    res_t             got[$];
    vec_t             tab[16];

    function automatic logic [OUT_N-1:0] bit1(input int k);
        logic [OUT_N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic string vs(input logic [OUT_N-1:0] v);
        return $sformatf("ones=%0d lo=%h msb=%b", $countones(v), v[31:0], v[OUT_N-1]);
    endfunction

    function automatic int dut_cnt();
`ifdef DECODER_PIPE_COUNT_EN
        return int'(out_cnt);
`else
        return $countones(out_vec);
`endif
    endfunction

    // Reference: apply one transaction to the abstract bit-vector state.
    function automatic res_t model(input logic [1:0] m, input int sel);
        res_t r;
        logic e;
        e = (sel >= OUT_N) && (m != 2'b11);
        case (m)
            2'b00: mvec = e ? '0 : bit1(sel);
            2'b01: if (!e) mvec[sel] = 1'b1;
            2'b10: if (!e) mvec[sel] = 1'b0;
            default: mvec = '0;
        endcase
        r.vec = mvec;
        r.err = e;
        r.cnt = $countones(mvec);
        r.cyc = 0;
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [OUT_N-1:0] act, input logic [OUT_N-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %s expected %s", nm, vs(act), vs(exp));
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_res(input string nm, input res_t e);
        nvec++;
        if (out_vec !== e.vec || out_err !== e.err || dut_cnt() != e.cnt) begin
            nerr++;
            $display("FAIL %s: got %s err=%b cnt=%0d expected %s err=%b cnt=%0d",
                     nm, vs(out_vec), out_err, dut_cnt(), vs(e.vec), e.err, e.cnt);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input int s, input logic r);
        in_valid  = v;
        in_mode   = m;
        in_sel    = IN_W'(s);
        out_ready = r;
    endtask

    // One clock: check outputs/handshakes before the edge, then advance.
    task automatic step();
        res_t a;
        @(negedge clk);
        chk1("in_ready", in_ready, (q.size() < 2) || out_ready);
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL stale_result: got out_valid=1 expected 0 with nothing in flight");
            end else begin
                cmp_res("result", q[0]);
                if (out_ready) begin
                    a.vec = out_vec;
                    a.err = out_err;
                    a.cnt = dut_cnt();
                    a.cyc = cyc;
                    got.push_back(a);
                    mlast = q[0].vec;
                    void'(q.pop_front());
                end
            end
        end else begin
            chkv("idle_hold", out_vec, mlast);
        end
        if (in_valid && in_ready) begin
            q.push_back(model(in_mode, int'(in_sel)));
            nacc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        drive(1'b0, 2'b00, 0, 1'b1);
        for (int k = 0; k < 10 && q.size() > 0; k++) step();
        chki("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        q.delete();
        mvec  = '0;
        mlast = '0;
        chk1("rst_out_valid", out_valid, 1'b0);
        chkv("rst_out_vec", out_vec, '0);
        chk1("rst_out_err", out_err, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chki("rst_cnt", dut_cnt(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int gbase;
        int k;
        int acc0;
        int sels[4];

        tab[0]  = '{MODE_CLR_ALL, 0,    '0,                     1'b0, 0};
        tab[1]  = '{MODE_ONEHOT,  5,    bit1(5),                1'b0, 1};
        tab[2]  = '{MODE_CLR_ALL, 77,   '0,                     1'b0, 0};
        tab[3]  = '{MODE_SET,     3,    bit1(3),                1'b0, 1};
        tab[4]  = '{MODE_SET,     999,  bit1(3) | bit1(999),    1'b0, 2};
        tab[5]  = '{MODE_CLR,     3,    bit1(999),              1'b0, 1};
        tab[6]  = '{MODE_ONEHOT,  1000, '0,                     1'b1, 0};
        tab[7]  = '{MODE_SET,     999,  bit1(999),              1'b0, 1};
        tab[8]  = '{MODE_SET,     1023, bit1(999),              1'b1, 1};
        tab[9]  = '{MODE_CLR,     1000, bit1(999),              1'b1, 1};
        tab[10] = '{MODE_SET,     7,    bit1(999) | bit1(7),    1'b0, 2};
        tab[11] = '{MODE_SET,     7,    bit1(999) | bit1(7),    1'b0, 2};
        tab[12] = '{MODE_CLR_ALL, 1023, '0,                     1'b0, 0};
        tab[13] = '{MODE_CLR,     7,    '0,                     1'b0, 0};
        tab[14] = '{MODE_ONEHOT,  0,    bit1(0),                1'b0, 1};
        tab[15] = '{MODE_CLR,     0,    '0,                     1'b0, 0};

        rst        = 1'b1;
        b_in_valid = 1'b0;
        b_in_sel   = '0;
        b_in_mode  = 2'b00;
        drive(1'b0, 2'b00, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Full-range instance: top select sets the MSB with no error.
        b_in_valid = 1'b1; b_in_mode = 2'b00; b_in_sel = 4'd15;
        @(posedge clk); #1;
        b_in_mode = 2'b01; b_in_sel = 4'd0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        nvec++;
        if (b_out_valid !== 1'b1 || b_out_vec !== 16'h8000 || b_out_err !== 1'b0) begin
            nerr++;
            $display("FAIL full_range_msb: got v=%b vec=%h err=%b expected v=1 vec=8000 err=0",
                     b_out_valid, b_out_vec, b_out_err);
        end
        @(posedge clk); #1;
        nvec++;
        if (b_out_vec !== 16'h8001 || b_out_err !== 1'b0) begin
            nerr++;
            $display("FAIL full_range_set: got vec=%h err=%b expected vec=8001 err=0", b_out_vec, b_out_err);
        end

        // Latency: result valid two edges after the accepting edge.
        drive(1'b1, MODE_ONEHOT, 5, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 0, 1'b1);
        chk1("lat_early_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("lat_valid", out_valid, 1'b1);
        chkv("lat_vec", out_vec, bit1(5));
        chk1("lat_err", out_err, 1'b0);
        chki("lat_cnt", dut_cnt(), 1);
        @(posedge clk); #1;
        chk1("lat_valid_fall", out_valid, 1'b0);
        chkv("lat_vec_hold", out_vec, bit1(5));
        mvec  = bit1(5);
        mlast = bit1(5);

        // Directed table, back to back with out_ready=1.
        gbase = got.size();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, tab[i].mode, tab[i].sel, 1'b1);
            step();
        end
        drain();
        chki("table_count", got.size() - gbase, 16);
        if (got.size() - gbase == 16) begin
            for (int i = 0; i < 16; i++) begin
                chkv($sformatf("tab%0d_vec", i), got[gbase+i].vec, tab[i].vec);
                chk1($sformatf("tab%0d_err", i), got[gbase+i].err, tab[i].err);
`ifdef DECODER_PIPE_COUNT_EN
                chki($sformatf("tab%0d_cnt", i), got[gbase+i].cnt, tab[i].cnt);
`endif
                chki($sformatf("tab%0d_cycle", i), got[gbase+i].cyc, got[gbase].cyc + i);
            end
        end

        // Stall: 5 cycles of out_ready=0 with 4 pending requests.
        sels  = '{11, 22, 33, 44};
        gbase = got.size();
        acc0  = nacc;
        k     = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, MODE_SET, sels[k], 1'b0);
            step();
            if (nacc - acc0 > k) k++;
        end
        chki("stall_accepted", k, 2);
        for (int c = 0; c < 10 && k < 4; c++) begin
            drive(1'b1, MODE_SET, sels[k], 1'b1);
            step();
            if (nacc - acc0 > k) k++;
        end
        drain();
        chki("stall_results", got.size() - gbase, 4);

        // Reset with two transactions in flight.
        drive(1'b1, MODE_SET, 100, 1'b1);
        step();
        drive(1'b1, MODE_SET, 200, 1'b1);
        step();
        do_reset();
        drive(1'b0, 2'b00, 0, 1'b1);
        repeat (5) step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            int r;
            int s;
            r = $urandom_range(0, 7);
            case (r)
                0: s = OUT_N - 1;
                1: s = OUT_N;
                2: s = 1023;
                3, 4: s = $urandom_range(0, 7);
                default: s = $urandom_range(0, 1023);
            endcase
            drive(($urandom % 4) != 0, 2'($urandom % 4), s, ($urandom % 4) != 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
